siso_tx_sched: RTL

Serial-transmit scheduler that shares one serial-in/serial-out shift lane between two parallel-word requesters. It arbitrates round-robin, loads the winning word into an internal WIDTH-bit shift register and clocks it out one bit per cycle. It then emits a completion pulse. It sits in front of the downstream SISO delay chain, sequencing all traffic onto its single serial input.

---
 rtl/siso_pkg.sv | 13 +
 rtl/siso_tx_sched_if.sv | 26 ++
 rtl/siso_tx_sched_rr_arb2.sv | 31 +++
 rtl/siso_tx_sched.sv | 114 +++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the SISO serial-lane family.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Inter-word spacer length in cycles.
    localparam int GAP_LEN = 1;

endpackage

// File: rtl/siso_tx_sched_if.sv
// Handshake and serial-lane bundle between two requesters and the scheduler.
interface siso_tx_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sout;
    logic             sout_en;
    logic             owner;
    logic             busy;
    logic             done;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sout, sout_en, owner, busy, done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sout, sout_en, owner, busy, done
    );
endinterface

// File: rtl/siso_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter; purely combinational, history kept by the parent.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_owner,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);
    always_comb begin
        o_grant     = 2'b00;
        o_grant_idx = 1'b0;
        case (i_valid)
            2'b01: begin
                o_grant     = 2'b01;
                o_grant_idx = 1'b0;
            end
            2'b10: begin
                o_grant     = 2'b10;
                o_grant_idx = 1'b1;
            end
            2'b11: begin
                // On a tie the requester that did not go last wins.
                o_grant     = i_last_owner ? 2'b01 : 2'b10;
                o_grant_idx = ~i_last_owner;
            end
            default: begin
                o_grant     = 2'b00;
                o_grant_idx = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/siso_tx_sched.sv
// Shares one serial shift lane between two parallel-word requesters:
// round-robin accept, WIDTH-bit serialisation, then a one-cycle done spacer.
module siso_tx_sched
    import siso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    siso_tx_sched_if.slave   bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_grant;
    logic             w_grant_idx;
    logic             w_accept;
    logic             w_ready0;
    logic             w_ready1;
    logic [WIDTH-1:0] w_load;
    logic             w_out_bit;

    rr_arb2 u_arb (
        .i_valid      ({bus.req1_valid, bus.req0_valid}),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready0 = w_grant[0];
                w_ready1 = w_grant[1];
                if (|w_grant) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bitcnt == LAST_BIT) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_load = w_grant_idx ? bus.req1_data : bus.req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // busy/done are registered copies of the upcoming state decode.
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == GAP);
            if (w_accept) begin
                r_shreg      <= w_load;
                r_owner      <= w_grant_idx;
                r_last_owner <= w_grant_idx;
                r_bitcnt     <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
                if (r_bitcnt != LAST_BIT) begin
                    r_bitcnt <= r_bitcnt + CW'(1);
                end
            end
        end
    end

    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.sout_en    = (r_state == SHIFT);
    assign bus.sout       = (r_state == SHIFT) & w_out_bit;
    assign bus.owner      = r_owner;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
